// File: rtl/aes_icipher_arb_pkg.sv
// Shared constants and types for the two-requester inverse-cipher arbiter.
// Nb/Nr mirror the AES-128 engine parameters.
package aes_icipher_arb_pkg;

  localparam int Nb     = 4;
  localparam int Nr     = 10;
  localparam int NBYTES = 4 * Nb;
  localparam int TMO    = Nr + 4;

  typedef logic [0:NBYTES-1][7:0] block_t;

  typedef enum logic [1:0] {IDLE, RUN, HOLD} arb_state_t;

  typedef struct packed {
    arb_state_t state;
    logic       id;
    logic       last;
    logic [3:0] cnt;
    logic       out_valid;
    logic       err;
  } arb_reg_t;

  // last=1 so requester 0 wins the first grant after reset
  localparam arb_reg_t REG_INIT = '{state: IDLE, id: 1'b0, last: 1'b1,
                                    cnt: 4'd0, out_valid: 1'b0, err: 1'b0};

endpackage

// File: rtl/aes_icipher_arb.sv
// Round-robin arbiter/sequencer sharing one iterative inverse-cipher engine
// between two block requesters, with a one-entry result buffer and watchdog.
module aes_icipher_arb
  import aes_icipher_arb_pkg::*;
(
  input  logic                     clk,
  input  logic                     rst,
  input  logic [1:0]               Req_valid,
  output logic [1:0]               Req_ready,
  input  logic [0:NBYTES-1][7:0]   Req_data0,
  input  logic [0:NBYTES-1][7:0]   Req_data1,
  output logic                     Eng_enable,
  output logic [0:NBYTES-1][7:0]   Eng_data,
  input  logic                     Eng_ready,
  input  logic [0:NBYTES-1][7:0]   Eng_result,
  output logic                     Out_valid,
  input  logic                     Out_ready,
  output logic [0:NBYTES-1][7:0]   Out_data,
  output logic                     Out_id,
  output logic                     Err_out
);

  arb_reg_t r, rin;
  logic [1:0] gnt;
  logic       g_pick;
  logic       buf_load;
  block_t     out_buf;
  logic       out_id_q;

  // With both valid, favour the one not granted last; otherwise the lone one.
  function automatic logic rr_pick(input logic [1:0] v, input logic last);
    if (v == 2'b11) return ~last;
    return v[1];
  endfunction

  assign g_pick = rr_pick(Req_valid, r.last);

  always_comb begin
    rin      = r;
    gnt      = '0;
    buf_load = 1'b0;
    case (r.state)
      IDLE: begin
        if (|Req_valid && !r.out_valid && !rst) begin
          gnt[g_pick] = 1'b1;
          rin.id      = g_pick;
          rin.last    = g_pick;
          rin.cnt     = '0;
          rin.state   = RUN;
        end
      end
      RUN: begin
        rin.cnt = r.cnt + 4'd1;
        if (Eng_ready) begin
          buf_load      = 1'b1;
          rin.out_valid = 1'b1;
          rin.state     = HOLD;
        end else if (r.cnt == 4'(TMO - 2)) begin
          // cnt lags the cycle count by one, so err rises TMO cycles after grant
          rin.err   = 1'b1;
          rin.state = IDLE;
        end
      end
      HOLD: begin
        if (Out_ready) begin
          rin.out_valid = 1'b0;
          rin.state     = IDLE;
        end
      end
      default: rin.state = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    r <= rst ? REG_INIT : rin;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_buf  <= '0;
      out_id_q <= 1'b0;
    end else if (buf_load) begin
      out_buf  <= Eng_result;
      out_id_q <= r.id;
    end
  end

  assign Req_ready  = gnt;
  assign Eng_enable = |gnt;
  assign Eng_data   = g_pick ? Req_data1 : Req_data0;
  assign Out_valid  = r.out_valid;
  assign Out_data   = out_buf;
  assign Out_id     = out_id_q;
  assign Err_out    = r.err;

endmodule
